// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back selector.
// Aligns and extends load data using big-endian byte lanes, then picks the
// write-back source. Flags misaligned loads and counts retired instructions.
// The register file commits these outputs on the following negedge.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic              in_jal,
    input  logic [2:0]        in_load_type,
    input  logic [1:0]        in_addr_lo,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_rdata,
    input  logic [DATA_W-1:0] in_pc_plus4,
    input  logic [REG_AW-1:0] in_write_reg,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              wb_valid,
    output logic              align_err,
    output logic              align_err_sticky,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;
    localparam logic [REG_AW-1:0] RA_REG = REG_AW'(31);

    // Select the addressed byte/halfword (byte 0 is the MSB lane) and extend it.
    // Undefined load types fall through to the full-word path.
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [2:0]        lt,
        input logic [1:0]        a,
        input logic [DATA_W-1:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = a[1] ? w[15:0] : w[31:16];
        case (lt)
            LT_LB:   load_extend = {{(DATA_W-8){b[7]}}, b};
            LT_LBU:  load_extend = {{(DATA_W-8){1'b0}}, b};
            LT_LH:   load_extend = {{(DATA_W-16){h[15]}}, h};
            LT_LHU:  load_extend = {{(DATA_W-16){1'b0}}, h};
            default: load_extend = w;
        endcase
    endfunction

    // Halfword loads need an even address; word (and undefined) loads need a zero offset.
    function automatic logic load_misaligned(
        input logic [2:0] lt,
        input logic [1:0] a
    );
        case (lt)
            LT_LB, LT_LBU: load_misaligned = 1'b0;
            LT_LH, LT_LHU: load_misaligned = a[0];
            default:       load_misaligned = (a != 2'd0);
        endcase
    endfunction

    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
    logic              err;
    logic              we;

    logic              regwrite_p1;
    logic [REG_AW-1:0] wreg_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic              vld_p1;
    logic              err_p1;
    logic              sticky_p1;
    logic [CNT_W-1:0]  retired_p1;

    // MEM stage: destination, write-back source, alignment check and write enable.
    always_comb begin
        dest = in_jal ? RA_REG : in_write_reg;
        data = in_jal      ? in_pc_plus4 :
               in_memtoreg ? load_extend(in_load_type, in_addr_lo, in_mem_rdata) :
                             in_alu_result;
        err  = in_valid & in_memtoreg & load_misaligned(in_load_type, in_addr_lo);
        we   = in_valid & in_regwrite & (dest != '0) & ~err;
    end

    // MEM -> WB register: reset clears all, flush inserts a bubble, stall holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_p1 <= 1'b0;
            wreg_p1     <= '0;
            wdata_p1    <= '0;
            vld_p1      <= 1'b0;
            err_p1      <= 1'b0;
            sticky_p1   <= 1'b0;
            retired_p1  <= '0;
        end else if (flush) begin
            regwrite_p1 <= 1'b0;
            wreg_p1     <= '0;
            wdata_p1    <= '0;
            vld_p1      <= 1'b0;
            err_p1      <= 1'b0;
        end else if (!stall) begin
            regwrite_p1 <= we;
            wreg_p1     <= dest;
            wdata_p1    <= data;
            vld_p1      <= in_valid;
            err_p1      <= err;
            sticky_p1   <= sticky_p1 | err;
            retired_p1  <= retired_p1 + CNT_W'(in_valid);
        end
    end

    assign RegWrite         = regwrite_p1;
    assign WriteRegister    = wreg_p1;
    assign WriteData        = wdata_p1;
    assign wb_valid         = vld_p1;
    assign align_err        = err_p1;
    assign align_err_sticky = sticky_p1;
    assign retired          = retired_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a negedge-committing register file model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        in_valid, in_regwrite, in_memtoreg, in_jal;
    logic [2:0]  in_load_type;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4;
    logic [4:0]  in_write_reg;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        wb_valid, align_err, align_err_sticky;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_ret = 0;
    logic [31:0] rf [32];

    mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_jal(in_jal), .in_load_type(in_load_type), .in_addr_lo(in_addr_lo),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_pc_plus4(in_pc_plus4), .in_write_reg(in_write_reg),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .wb_valid(wb_valid), .align_err(align_err),
        .align_err_sticky(align_err_sticky), .retired(retired)
    );

    always #5 clk = ~clk;

    // Register file: commits on negedge, $0 never written.
    always @(negedge clk) begin
        if (RegWrite && WriteRegister != 5'd0) rf[WriteRegister] <= WriteData;
    end

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic j,
                         input logic [2:0] lt, input logic [1:0] a, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [31:0] pc, input logic [4:0] wr);
        in_valid = v; in_regwrite = rw; in_memtoreg = m2r; in_jal = j;
        in_load_type = lt; in_addr_lo = a; in_alu_result = alu;
        in_mem_rdata = rd; in_pc_plus4 = pc; in_write_reg = wr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; flush = 0;
        drive(1, 1, 0, 0, 3'd0, 2'd0, 32'hDEAD_BEEF, 0, 0, 5'd7);
        tick(); tick();
        reset = 0;
        drive(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 5'd0);
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%0b exp=0", RegWrite); end
        checks++; if (WriteRegister !== 5'd0) begin failures++; $display("FAIL reset_wreg got=%0d exp=0", WriteRegister); end
        checks++; if (WriteData !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", WriteData); end
        checks++; if (wb_valid !== 1'b0 || align_err !== 1'b0 || align_err_sticky !== 1'b0) begin
            failures++; $display("FAIL reset_flags got=%b%b%b exp=000", wb_valid, align_err, align_err_sticky); end
        checks++; if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        exp_ret = 0;
    endtask

    task automatic test_alu();
        drive(1, 1, 0, 0, 3'd0, 2'd0, 32'h0000_1234, 32'hFFFF_FFFF, 32'h100, 5'd8);
        tick(); exp_ret++;
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd8 || WriteData !== 32'h1234) begin
            failures++; $display("FAIL alu_wb got=%b/%0d/%h exp=1/8/00001234", RegWrite, WriteRegister, WriteData); end
        checks++; if (wb_valid !== 1'b1 || retired !== exp_ret) begin
            failures++; $display("FAIL alu_valid got=%b/%0d exp=1/%0d", wb_valid, retired, exp_ret); end
        @(negedge clk); #1;
        checks++; if (rf[8] !== 32'h1234) begin failures++; $display("FAIL alu_rf8 got=%h exp=00001234", rf[8]); end
    endtask

    task automatic test_loads();
        logic [2:0]  lt  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd3, 3'd7};
        logic [1:0]  ad  [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
        logic [31:0] exv [8] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_7F01, 32'h0000_80FF,
                                 32'h80FF_7F01, 32'h0000_0001, 32'hFFFF_80FF, 32'h80FF_7F01};
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 0, lt[i], ad[i], 32'h5555_5555, 32'h80FF_7F01, 32'h0, 5'd10);
            tick(); exp_ret++;
            checks++; if (WriteData !== exv[i] || RegWrite !== 1'b1 || align_err !== 1'b0) begin
                failures++; $display("FAIL load_%0d got=%h/%b/%b exp=%h/1/0", i, WriteData, RegWrite, align_err, exv[i]); end
        end
        checks++; if (retired !== exp_ret) begin failures++; $display("FAIL load_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_jal();
        drive(1, 1, 0, 1, 3'd0, 2'd0, 32'h1111_1111, 0, 32'h0040_0010, 5'd5);
        tick(); exp_ret++;
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd31 || WriteData !== 32'h0040_0010) begin
            failures++; $display("FAIL jal_wb got=%b/%0d/%h exp=1/31/00400010", RegWrite, WriteRegister, WriteData); end
        drive(1, 1, 0, 0, 3'd0, 2'd0, 32'h0000_00AB, 0, 0, 5'd0);
        tick(); exp_ret++;
        checks++; if (RegWrite !== 1'b0 || wb_valid !== 1'b1 || WriteData !== 32'hAB) begin
            failures++; $display("FAIL r0_suppress got=%b/%b/%h exp=0/1/000000ab", RegWrite, wb_valid, WriteData); end
        checks++; if (retired !== exp_ret) begin failures++; $display("FAIL r0_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_align();
        drive(0, 1, 1, 0, 3'd3, 2'd1, 0, 32'h1234_5678, 0, 5'd9);
        tick();
        checks++; if (align_err !== 1'b0 || align_err_sticky !== 1'b0 || wb_valid !== 1'b0) begin
            failures++; $display("FAIL align_invalid got=%b/%b/%b exp=0/0/0", align_err, align_err_sticky, wb_valid); end
        drive(1, 1, 1, 0, 3'd3, 2'd1, 0, 32'h1234_5678, 0, 5'd9);
        tick(); exp_ret++;
        checks++; if (RegWrite !== 1'b0 || align_err !== 1'b1 || align_err_sticky !== 1'b1) begin
            failures++; $display("FAIL align_lh got=%b/%b/%b exp=0/1/1", RegWrite, align_err, align_err_sticky); end
        drive(1, 1, 1, 0, 3'd0, 2'd2, 0, 32'h1234_5678, 0, 5'd9);
        tick(); exp_ret++;
        checks++; if (RegWrite !== 1'b0 || align_err !== 1'b1) begin
            failures++; $display("FAIL align_lw got=%b/%b exp=0/1", RegWrite, align_err); end
        drive(1, 1, 0, 0, 3'd0, 2'd1, 32'h42, 0, 0, 5'd9);
        tick(); exp_ret++;
        checks++; if (RegWrite !== 1'b1 || align_err !== 1'b0 || align_err_sticky !== 1'b1) begin
            failures++; $display("FAIL align_clean got=%b/%b/%b exp=1/0/1", RegWrite, align_err, align_err_sticky); end
        checks++; if (retired !== exp_ret) begin failures++; $display("FAIL align_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 0, 0, 3'd0, 2'd0, 32'hA, 0, 0, 5'd11);
        tick(); exp_ret++;
        drive(1, 1, 0, 0, 3'd0, 2'd0, 32'hB, 0, 0, 5'd12);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (WriteRegister !== 5'd11 || WriteData !== 32'hA || RegWrite !== 1'b1 || retired !== exp_ret) begin
                failures++; $display("FAIL hold_a_%0d got=%0d/%h/%b/%0d exp=11/0000000a/1/%0d",
                                     i, WriteRegister, WriteData, RegWrite, retired, exp_ret); end
            if (i < 2) tick();
        end
        stall = 0;
        tick(); exp_ret++;
        checks++; if (WriteRegister !== 5'd12 || WriteData !== 32'hB || retired !== exp_ret) begin
            failures++; $display("FAIL capture_b got=%0d/%h/%0d exp=12/0000000b/%0d", WriteRegister, WriteData, retired, exp_ret); end
        drive(1, 1, 0, 0, 3'd0, 2'd0, 32'hC, 0, 0, 5'd13);
        flush = 1; stall = 1;
        tick();
        flush = 0; stall = 0;
        checks++; if (RegWrite !== 1'b0 || wb_valid !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 32'd0) begin
            failures++; $display("FAIL flush_bubble got=%b/%b/%0d/%h exp=0/0/0/0", RegWrite, wb_valid, WriteRegister, WriteData); end
        checks++; if (retired !== exp_ret || align_err_sticky !== 1'b1) begin
            failures++; $display("FAIL flush_keep got=%0d/%b exp=%0d/1", retired, align_err_sticky, exp_ret); end
    endtask

    task automatic test_reset_stall();
        drive(1, 1, 0, 0, 3'd0, 2'd0, 32'h66, 0, 0, 5'd13);
        tick();
        stall = 1; reset = 1;
        tick();
        reset = 0; stall = 0;
        checks++; if (RegWrite !== 1'b0 || wb_valid !== 1'b0 || WriteData !== 32'd0 || retired !== 32'd0 || align_err_sticky !== 1'b0) begin
            failures++; $display("FAIL reset_stall got=%b/%b/%h/%0d/%b exp=0/0/0/0/0", RegWrite, wb_valid, WriteData, retired, align_err_sticky); end
        drive(1, 1, 0, 0, 3'd0, 2'd0, 32'h77, 0, 0, 5'd14);
        tick();
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd14 || WriteData !== 32'h77 || retired !== 32'd1) begin
            failures++; $display("FAIL post_reset got=%b/%0d/%h/%0d exp=1/14/00000077/1", RegWrite, WriteRegister, WriteData, retired); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        reset = 1; stall = 0; flush = 0;
        drive(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 5'd0);
        #2;
        test_reset();
        test_alu();
        test_loads();
        test_jal();
        test_align();
        test_back_to_back();
        test_reset_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
